// File: rtl/display_scan_controller_pkg.sv
// Shared constants and state encoding for the multiplexed seven-segment scan controller.
package display_scan_controller_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    // Sliced down to NUM_DIGITS by the user; common-anode selects are active low.
    localparam logic [MAX_DIGITS-1:0] SEL_OFF = '1;

    typedef enum logic {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// Slot-duration counter: counts 0..PRESCALE-1 while running and flags the last count of each slot.
module scan_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
            tick    = 1'b1;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes one hex decoder across NUM_DIGITS common-anode digits, committing
// newly loaded values only at frame boundaries so a frame never mixes old and new digits.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          blank_lz,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    output logic                          ack,
    output logic [DIGIT_W-1:0]            digit_code,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_start
);

    localparam int VAL_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [VAL_W-1:0]        display_q, display_d;
    logic [VAL_W-1:0]        shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    ack_q, ack_d;
    logic                    frame_start_q, frame_start_d;
    logic [DIGIT_W-1:0]      digit_code_q, digit_code_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;

    logic                    clear;
    logic                    tick;
    logic                    running;
    logic                    boundary;
    logic                    commit;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_blank;

    assign running = (state_q == ST_SCAN) && en;
    assign clear   = !running;

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    // Outputs are registered from the next-cycle slot so the pins line up with the slot being entered.
    always_comb begin
        state_d       = en ? ST_SCAN : ST_OFF;
        idx_d         = '0;
        boundary      = 1'b0;
        if (running) begin
            idx_d = idx_q;
            if (tick) begin
                idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                boundary = (idx_q == LAST_IDX);
            end
        end

        // A load arriving with a commit refills the shadow and stays pending for the next frame.
        commit        = pending_q && (boundary || (state_q == ST_OFF));
        display_d     = commit ? shadow_q : display_q;
        shadow_d      = load ? value : shadow_q;
        pending_d     = load || (pending_q && !commit);
        ack_d         = commit;
        frame_start_d = (state_d == ST_SCAN) && ((state_q == ST_OFF) || boundary);

        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (display_d[i*DIGIT_W +: DIGIT_W] == '0);
            lz_blank[i] = zero_run;
        end

        digit_code_d = '0;
        digit_sel_d  = SEL_OFF[NUM_DIGITS-1:0];
        if (state_d == ST_SCAN) begin
            digit_code_d = display_d[int'(idx_d)*DIGIT_W +: DIGIT_W];
            if (!(blank_lz && lz_blank[idx_d])) begin
                digit_sel_d[idx_d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_OFF;
            idx_q         <= '0;
            display_q     <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            ack_q         <= 1'b0;
            frame_start_q <= 1'b0;
            digit_code_q  <= '0;
            digit_sel_q   <= SEL_OFF[NUM_DIGITS-1:0];
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            display_q     <= display_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            ack_q         <= ack_d;
            frame_start_q <= frame_start_d;
            digit_code_q  <= digit_code_d;
            digit_sel_q   <= digit_sel_d;
        end
    end

    assign ack         = ack_q;
    assign frame_start = frame_start_q;
    assign digit_code  = digit_code_q;
    assign digit_sel   = digit_sel_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with PRESCALE=4, NUM_DIGITS=4 (16-cycle frames).
module tb_display_scan_controller;

    localparam int NUM_DIGITS = 4;
    localparam int PRESCALE   = 4;
    localparam int FRAME_CYC  = NUM_DIGITS * PRESCALE;
    localparam int NUM_FRAMES = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        blank_lz;
    logic        load;
    logic [15:0] value;
    logic        ack;
    logic [3:0]  digit_code;
    logic [3:0]  digit_sel;
    logic        frame_start;

    always #5 clk = ~clk;

    display_scan_controller #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .blank_lz    (blank_lz),
        .load        (load),
        .value       (value),
        .ack         (ack),
        .digit_code  (digit_code),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] code;
        logic       fs;
        logic       ack;
    } obs_t;

    // One record per frame: what to load during it, and what it must display.
    typedef struct {
        logic [15:0] shown;
        logic [15:0] sel_map;
        logic        ack_at_start;
        logic        blank;
        int          load_cyc_a;
        logic [15:0] load_val_a;
        int          load_cyc_b;
        logic [15:0] load_val_b;
    } frame_vec_t;

    obs_t       exp_q[$];
    frame_vec_t frames[NUM_FRAMES];
    int         checks = 0;
    int         passes = 0;

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic expectNext(input logic [3:0] sel, input logic [3:0] code,
                              input logic fs, input logic a);
        obs_t e;
        e.sel  = sel;
        e.code = code;
        e.fs   = fs;
        e.ack  = a;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] val);
        load = ld;
        if (ld) value = val;
    endtask

    task automatic checkOutput(input string name);
        obs_t e;
        obs_t got;
        got.sel  = digit_sel;
        got.code = digit_code;
        got.fs   = frame_start;
        got.ack  = ack;
        checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL %s: no expected entry queued, got sel=%b code=%h fs=%b ack=%b",
                     name, got.sel, got.code, got.fs, got.ack);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                $display("[TB] FAIL %s: got sel=%b code=%h fs=%b ack=%b, expected sel=%b code=%h fs=%b ack=%b",
                         name, got.sel, got.code, got.fs, got.ack, e.sel, e.code, e.fs, e.ack);
            end else begin
                passes++;
            end
        end
    endtask

    initial begin
        int slot;

        // sel_map nibble k is the digit_sel pattern during slot k.
        frames[0] = '{16'h0000, 16'h7BDE, 1'b0, 1'b0, -1, 16'h0000, -1, 16'h0000};
        frames[1] = '{16'h0000, 16'h7BDE, 1'b0, 1'b0,  6, 16'h1234, -1, 16'h0000};
        frames[2] = '{16'h1234, 16'h7BDE, 1'b1, 1'b0,  2, 16'h1111,  9, 16'h2222};
        frames[3] = '{16'h2222, 16'h7BDE, 1'b1, 1'b0,  5, 16'h0009, 15, 16'h5678};
        frames[4] = '{16'h0009, 16'h7BDE, 1'b1, 1'b0, -1, 16'h0000, -1, 16'h0000};
        frames[5] = '{16'h5678, 16'h7BDE, 1'b1, 1'b1,  3, 16'h0040, -1, 16'h0000};
        frames[6] = '{16'h0040, 16'hFFDE, 1'b1, 1'b1,  4, 16'h0000, -1, 16'h0000};
        frames[7] = '{16'h0000, 16'hFFFE, 1'b1, 1'b1, -1, 16'h0000, -1, 16'h0000};

        reset    = 1'b1;
        en       = 1'b0;
        blank_lz = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;

        stepClock();
        expectNext(4'b1111, 4'h0, 1'b0, 1'b0);
        stepClock();
        checkOutput("reset_state");

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expectNext(4'b1111, 4'h0, 1'b0, 1'b0);
            stepClock();
            checkOutput("idle_off");
        end

        en = 1'b1;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            for (int c = 0; c < FRAME_CYC; c++) begin
                slot = c / PRESCALE;
                expectNext(frames[f].sel_map[slot*4 +: 4], frames[f].shown[slot*4 +: 4],
                           c == 0, frames[f].ack_at_start && (c == 0));
                stepClock();
                checkOutput($sformatf("frame%0d_cyc%0d", f, c));
                if (c == frames[f].load_cyc_b) begin
                    applyStimulus(1'b1, frames[f].load_val_b);
                end else if (c == frames[f].load_cyc_a) begin
                    applyStimulus(1'b1, frames[f].load_val_a);
                end else begin
                    applyStimulus(1'b0, 16'h0000);
                end
                if (c == 0) blank_lz = frames[f].blank;
            end
        end

        // Load at a non-committing boundary, then drop en mid-slot while it is pending.
        blank_lz = 1'b0;
        applyStimulus(1'b1, 16'h00AB);
        expectNext(4'b1110, 4'h0, 1'b1, 1'b0);
        stepClock();
        checkOutput("lz_off_slot0");
        applyStimulus(1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            expectNext(4'b1110, 4'h0, 1'b0, 1'b0);
            stepClock();
            checkOutput("pending_slot0_old");
        end
        en = 1'b0;
        expectNext(4'b1111, 4'h0, 1'b0, 1'b0);
        stepClock();
        checkOutput("en_drop_off");
        expectNext(4'b1111, 4'h0, 1'b0, 1'b1);
        stepClock();
        checkOutput("off_commit_ack");
        expectNext(4'b1111, 4'h0, 1'b0, 1'b0);
        stepClock();
        checkOutput("off_after_ack");

        en = 1'b1;
        for (int c = 0; c < PRESCALE + 1; c++) begin
            if (c < PRESCALE) expectNext(4'b1110, 4'hB, c == 0, 1'b0);
            else              expectNext(4'b1101, 4'hA, 1'b0, 1'b0);
            stepClock();
            checkOutput($sformatf("rescan_cyc%0d", c));
        end

        // Asynchronous reset between clock edges must clear the pins immediately.
        #2;
        reset = 1'b1;
        #1;
        expectNext(4'b1111, 4'h0, 1'b0, 1'b0);
        checkOutput("async_reset_now");
        expectNext(4'b1111, 4'h0, 1'b0, 1'b0);
        stepClock();
        checkOutput("async_reset_held");
        reset = 1'b0;
        expectNext(4'b1110, 4'h0, 1'b1, 1'b0);
        stepClock();
        checkOutput("after_reset_display_cleared");

        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes one shared seven-segment decoder across NUM_DIGITS common-anode digits.
- Presents one 4-bit digit code per refresh slot and drives active-low digit selects.
- Accepts new display values through a load/ack handshake, committed only at frame boundaries so a frame never shows mixed old and new digits.
- Sits between the numeric datapath (counters, score registers) and the hex decoder and board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clk cycles per digit slot (>=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  1 = scanning, 0 = display off
- blank_lz  input  1  1 = blank leading zero digits
- load  input  1  single-cycle request to capture value
- value  input  4*NUM_DIGITS  packed digits, digit 0 in bits [3:0]
- ack  output  1  one-cycle pulse when a captured value becomes visible
- digit_code  output  4  hex digit routed to the shared decoder
- digit_sel  output  NUM_DIGITS  active-low digit enables, at most one low
- frame_start  output  1  one-cycle pulse when slot 0 begins

Behaviour:
- Reset (async, active-high) clears everything: state OFF, prescale count 0, index 0, display_reg 0, shadow 0, pending 0, ack 0, frame_start 0, digit_code 0, digit_sel all ones.
- States:
  - OFF: digit_sel all ones; prescaler and index held at 0.
  - SCAN: cycling through digit slots.
  - OFF->SCAN when en=1. Slot 0 is driven on the cycle after en is sampled high, and frame_start pulses with it.
  - SCAN->OFF when en=0. Takes effect on the next cycle regardless of position; index and prescaler return to 0.
- Prescaler:
  - In SCAN, counts 0..PRESCALE-1 and wraps.
  - tick is asserted when count==PRESCALE-1.
  - On tick, index advances by 1 and wraps NUM_DIGITS-1 -> 0. That wrap is the frame boundary.
- Outputs are registered, one cycle latency from index:
  - digit_code = display_reg nibble[index].
  - digit_sel bit[index] = 0 unless the digit is blanked.
  - frame_start pulses on the cycle slot 0 is first driven.
- Leading-zero blank (blank_lz=1):
  - Digits from the MSB downward are blanked while zero.
  - Digit 0 is never blanked.
  - A blanked slot keeps its full duration with digit_sel all ones.
  - Blank status is computed from display_reg, never from shadow.
- Load handshake:
  - load=1 captures value into shadow and sets pending.
  - A further load while pending overwrites shadow; the last value wins and only one ack is produced.
- Commit:
  - In SCAN, at a frame-boundary tick with pending=1: display_reg <= shadow, pending <= 0, ack=1 on the following cycle.
  - In OFF, a pending value commits on the next cycle, with ack the cycle after.
- Simultaneous load and committing boundary tick:
  - The old shadow commits.
  - The new value enters shadow with pending kept at 1, so it commits at the next boundary.
  - Simultaneous load with a non-committing tick: captured normally.
- en deasserted mid-frame with pending=1: commits through the OFF rule. No value is ever lost.
- blank_lz and en are sampled every cycle; changes apply to the next driven slot.

Decomposition:
- Shared package holds:
  - DIGIT_W = 4.
  - Active-low select constant SEL_OFF (all ones).
  - State encoding constants ST_OFF and ST_SCAN.
- One natural sub-module: scan_prescaler.
  - Parameter PRESCALE; ports clk, reset, clear, tick.
  - Instantiated once.
- The decoder is instantiated by the parent, outside this block.

Test Plan (PRESCALE=4, NUM_DIGITS=4):
1. Reset held, then en=1 with display_reg 0: digit_sel steps 1110, 1101, 1011, 0111 every 4 cycles; digit_code 0; frame_start pulses every 16 cycles.
2. Load value 0x1234 mid-frame: digits keep showing 0 until the boundary. The next frame shows 4,3,2,1 on digits 0..3, and ack pulses exactly once, one cycle after commit.
3. Load 0x1111, then load 0x2222 before the boundary: a single ack, and the display shows 2s only; 0x1111 is never visible.
4. Load 0x5678 coincident with a boundary tick while 0x0009 is pending: frame N+1 shows 0x0009 with an ack, frame N+2 shows 0x5678 with a second ack.
5. blank_lz=1 with value 0x0040: digits 3 and 2 have digit_sel 1111 in their slots, digit 1 shows 4, digit 0 shows 0. With value 0x0000, only digit 0 is lit.
6. en dropped mid-slot with a load pending: digit_sel is 1111 on the next cycle and ack follows within 2 cycles. Async reset asserted mid-frame clears outputs immediately without waiting for a clk edge.
